// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU fetch definitions: datapath width, reset PC, fetch FSM states.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Word alignment of a fetch target.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_adder.sv
// Next-PC adder: (a ? rs1 : pc) + (b ? imm : 4), bit 0 cleared for jalr.
module npc_adder
    import pc_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm,
    input  logic            nxt_a_src,
    input  logic            nxt_b_src,
    output logic [XLEN-1:0] npc
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    // if/else so an unknown select falls back to the sequential PC+4 path
    always_comb begin
        base   = pc;
        offset = PC_STEP;
        if (nxt_a_src) begin
            base = rs1_data;
        end
        if (nxt_b_src) begin
            offset = imm;
        end
        npc = base + offset;
        if (nxt_a_src) begin
            npc[0] = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: boot, fetch handshake, execute/commit, sticky misaligned-target halt.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            nxt_a_src,
    input  logic            nxt_b_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm,
    input  logic            commit,
    output logic            imem_req,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic            trap
);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_d;
    logic            trap_d;
    logic            imem_req_d;
    logic            instr_valid_d;
    logic [XLEN-1:0] npc;

    npc_adder u_npc_adder (
        .pc        (pc),
        .rs1_data  (rs1_data),
        .imm       (imm),
        .nxt_a_src (nxt_a_src),
        .nxt_b_src (nxt_b_src),
        .npc       (npc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc          <= RESET_PC;
            trap        <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            trap        <= trap_d;
            imem_req    <= imem_req_d;
            instr_valid <= instr_valid_d;
        end
    end

    // Outputs are registered from the next state so they align with state_q.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        trap_d  = trap;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    if (is_aligned(npc)) begin
                        pc_d    = npc;
                        state_d = FETCH;
                    end else begin
                        trap_d  = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == EXEC);
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed + randomized bench for pc_fetch_unit against a behavioural fetch model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt_a_src;
    logic        nxt_b_src;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic        commit;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] pc;
    logic        instr_valid;
    logic        trap;

    int checks = 0;
    int errors = 0;

    // Model: 0 = boot cycle, 1 = waiting on memory, 2 = instruction held, 3 = dead
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_trap;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .nxt_a_src   (nxt_a_src),
        .nxt_b_src   (nxt_b_src),
        .rs1_data    (rs1_data),
        .imm         (imm),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .instr_valid (instr_valid),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".imem_req"}, 32'(imem_req), 32'(m_phase == 1));
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_phase == 2));
        check({tag, ".trap"}, 32'(trap), 32'(m_trap));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0000_0000;
        m_trap  = 1'b0;
    endtask

    // Spec rules evaluated at a rising edge; unknown selects count as 0.
    task automatic model_edge();
        logic [31:0] target;
        if (rst === 1'b1) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ready === 1'b1) m_phase = 2;
        end else if (m_phase == 2 && commit === 1'b1) begin
            target = ((nxt_a_src === 1'b1) ? rs1_data : m_pc)
                   + ((nxt_b_src === 1'b1) ? imm : 32'd4);
            if (nxt_a_src === 1'b1) target = target & 32'hFFFF_FFFE;
            if (target % 4 == 0) begin
                m_pc    = target;
                m_phase = 1;
            end else begin
                m_trap  = 1'b1;
                m_phase = 3;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, then released.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    task automatic do_commit(input logic a, input logic b, input logic [31:0] r,
                             input logic [31:0] i, input string tag);
        nxt_a_src = a;
        nxt_b_src = b;
        rs1_data  = r;
        imm       = i;
        commit    = 1'b1;
        step(tag);
        commit    = 1'b0;
    endtask

    task automatic fetch(input int stalls, input string tag);
        imem_ready = 1'b0;
        repeat (stalls) step({tag, ".stall"});
        imem_ready = 1'b1;
        step(tag);
    endtask

    initial begin
        rst = 1'b1;
        nxt_a_src = 1'b0;
        nxt_b_src = 1'b0;
        rs1_data = '0;
        imm = '0;
        commit = 1'b0;
        imem_ready = 1'b1;
        model_reset();

        // Reset and boot
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        check("boot.req", 32'(imem_req), 32'd0);
        step("boot_to_fetch");
        check("boot.req_next", 32'(imem_req), 32'd1);
        step("fetch_to_exec");
        check("boot.valid", 32'(instr_valid), 32'd1);

        // Sequential commit at 0x100
        do_commit(1'b1, 1'b1, 32'h0000_0100, 32'h0, "jump_100");
        fetch(0, "fetch_100");
        do_commit(1'b0, 1'b0, 32'h0, 32'h0, "seq_104");
        check("seq.pc", pc, 32'h0000_0104);
        check("seq.req", 32'(imem_req), 32'd1);
        fetch(0, "fetch_104");

        // Backward branch with stalled memory
        do_commit(1'b1, 1'b1, 32'h0000_0200, 32'h0, "jump_200");
        fetch(0, "fetch_200");
        do_commit(1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0, "branch");
        check("branch.pc", pc, 32'h0000_01F0);
        fetch(3, "fetch_1f0");
        check("branch.exec", 32'(instr_valid), 32'd1);

        // jalr with bit 0 clearing
        do_commit(1'b1, 1'b1, 32'h0000_1001, 32'h0000_0007, "jalr");
        check("jalr.pc", pc, 32'h0000_1008);
        check("jalr.trap", 32'(trap), 32'd0);
        fetch(1, "fetch_1008");

        // Unknown selects fall back to PC+4
        do_commit(1'bx, 1'bx, 32'h0000_0013, 32'h0000_0022, "xsel");
        check("xsel.pc", pc, 32'h0000_100C);
        fetch(0, "fetch_100c");

        // Randomized traffic with occasional misaligned targets and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset("rnd_rst");
            end
            nxt_a_src  = 1'($urandom_range(0, 1));
            nxt_b_src  = 1'($urandom_range(0, 1));
            rs1_data   = $urandom & 32'hFFFF_FFFC;
            imm        = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) imm[1:0] = 2'($urandom_range(1, 3));
            commit     = 1'($urandom_range(0, 1));
            imem_ready = ($urandom_range(0, 3) != 0);
            step("rnd");
        end
        commit = 1'b0;
        imem_ready = 1'b1;

        // Misaligned target traps and halts
        pulse_reset("mis_rst");
        step("mis_boot");
        step("mis_fetch");
        do_commit(1'b1, 1'b1, 32'h0000_0300, 32'h0, "jump_300");
        fetch(0, "fetch_300");
        do_commit(1'b0, 1'b1, 32'h0, 32'h0000_0002, "misaligned");
        check("mis.trap", 32'(trap), 32'd1);
        check("mis.pc", pc, 32'h0000_0300);
        for (int n = 0; n < 4; n++) begin
            do_commit(1'b0, 1'b0, 32'h0, 32'h0, "halt_commit");
            imem_ready = 1'($urandom_range(0, 1));
            step("halt_ready");
        end
        check("halt.req", 32'(imem_req), 32'd0);
        imem_ready = 1'b1;

        // Wrap-around then reset during a fetch
        pulse_reset("wrap_rst");
        step("wrap_boot");
        step("wrap_fetch");
        do_commit(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, "jump_fffc");
        fetch(0, "fetch_fffc");
        do_commit(1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.pc", pc, 32'h0000_0000);
        imem_ready = 1'b0;
        step("wrap_stall");
        pulse_reset("midfetch_rst");
        check("midfetch.req", 32'(imem_req), 32'd0);
        imem_ready = 1'b1;
        step("post_boot");
        step("post_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
